// File: rtl/rb_access_arbiter_if.sv
// Bundle of both master request/ack channels and the register-bank port
// shared between the arbiter (slave side) and its requesters/bank (master side).
interface rb_access_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_ack;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_ack;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_wdata;
  logic              rb_we;
  logic              rb_re;
  logic [DATA_W-1:0] rb_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  rb_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output rb_addr, rb_wdata, rb_we, rb_re
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output rb_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  rb_addr, rb_wdata, rb_we, rb_re
  );
endinterface

// File: rtl/rb_access_arbiter.sv
// Two-master round-robin arbiter for a single register bank with fixed
// read latency; one transaction in flight at a time.
module rb_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 resetb,
  rb_access_arbiter_if.slave   bus,
  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] CNT_LOAD = 2'(RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic              grant;
  logic              sel;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic [1:0]        cnt_q;

  // On a tie the master that was not served last wins.
  always_comb begin
    grant = bus.m0_req | bus.m1_req;
    sel   = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      sel = ~owner;
    end else if (bus.m1_req) begin
      sel = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy          = (state != IDLE);
    bus.rb_we     = 1'b0;
    bus.rb_re     = 1'b0;
    bus.m0_ack    = 1'b0;
    bus.m1_ack    = 1'b0;
    bus.rb_addr   = addr_q;
    bus.rb_wdata  = wdata_q;
    bus.m0_rdata  = m0_rdata_q;
    bus.m1_rdata  = m1_rdata_q;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.rb_we = we_q;
        bus.rb_re = ~we_q;
        state_nxt = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          state_nxt = ACK;
        end
      end
      ACK: begin
        bus.m0_ack = ~owner;
        bus.m1_ack = owner;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction fields are latched at selection so later changes on the
  // master side cannot disturb the access in flight.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      owner      <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      cnt_q      <= 2'd0;
    end else begin
      if (state == IDLE && grant) begin
        owner   <= sel;
        we_q    <= sel ? bus.m1_we    : bus.m0_we;
        addr_q  <= sel ? bus.m1_addr  : bus.m0_addr;
        wdata_q <= sel ? bus.m1_wdata : bus.m0_wdata;
      end
      if (state == ISSUE && !we_q) begin
        cnt_q <= CNT_LOAD;
      end
      if (state == WAIT) begin
        if (cnt_q == 2'd0) begin
          if (owner) begin
            m1_rdata_q <= bus.rb_rdata;
          end else begin
            m0_rdata_q <= bus.rb_rdata;
          end
        end else begin
          cnt_q <= cnt_q - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rb_access_arbiter.sv
// Scoreboard bench for rb_access_arbiter with a pipelined register-bank model
// whose read data is valid only in the cycle RD_LAT after rb_re.
module tb_rb_access_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic resetb;
  logic busy;
  logic owner;

  always #5 clk = ~clk;

  rb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  rb_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .clk    (clk),
    .resetb (resetb),
    .bus    (bus),
    .busy   (busy),
    .owner  (owner)
  );

  typedef struct {
    bit         m;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } txn_t;

  txn_t       iss_q[$];
  txn_t       ack_q[$];
  txn_t       mt;
  logic [7:0] model_rd [2];
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] bank_val(input logic [7:0] a);
    return (a == 8'h07) ? 8'h3C : (a ^ 8'hA5);
  endfunction

  // Bank read pipeline; outside the valid cycle the bus carries junk.
  bit         pipe_v [RD_LAT];
  logic [7:0] pipe_d [RD_LAT];
  always @(posedge clk) begin
    pipe_v[0] <= bus.rb_re;
    pipe_d[0] <= bank_val(bus.rb_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign bus.rb_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 8'hEE;

  // Monitor: every bank access and every ack must match the scoreboard head.
  always @(negedge clk) begin
    if (resetb === 1'b1) begin
      if (bus.rb_we || bus.rb_re) begin
        checks++;
        if (iss_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL issue_unexpected: we=%0b re=%0b addr=%h, required no access",
                   bus.rb_we, bus.rb_re, bus.rb_addr);
        end else begin
          mt = iss_q.pop_front();
          if ({bus.rb_we, bus.rb_re, owner, bus.rb_addr, bus.rb_wdata} !==
              {mt.we, !mt.we, mt.m, mt.addr, mt.wdata}) begin
            errors++;
            $display("[TB] FAIL issue: we=%0b re=%0b owner=%0b addr=%h wdata=%h, required we=%0b re=%0b owner=%0b addr=%h wdata=%h",
                     bus.rb_we, bus.rb_re, owner, bus.rb_addr, bus.rb_wdata,
                     mt.we, !mt.we, mt.m, mt.addr, mt.wdata);
          end
        end
      end
      if (bus.m0_ack || bus.m1_ack) begin
        checks++;
        if (ack_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL ack_unexpected: m0_ack=%0b m1_ack=%0b, required none",
                   bus.m0_ack, bus.m1_ack);
        end else begin
          mt = ack_q.pop_front();
          if ({bus.m0_ack, bus.m1_ack, busy, (mt.m ? bus.m1_rdata : bus.m0_rdata)} !==
              {!mt.m, mt.m, 1'b1, mt.rdata}) begin
            errors++;
            $display("[TB] FAIL ack: m0_ack=%0b m1_ack=%0b busy=%0b rdata=%h, required m0_ack=%0b m1_ack=%0b busy=1 rdata=%h",
                     bus.m0_ack, bus.m1_ack, busy, (mt.m ? bus.m1_rdata : bus.m0_rdata),
                     !mt.m, mt.m, mt.rdata);
          end
        end
      end
    end
  end

  task automatic expect_txn(input bit m, input bit we, input logic [7:0] a, input logic [7:0] wd);
    txn_t t;
    t.m = m; t.we = we; t.addr = a; t.wdata = wd;
    if (!we) model_rd[m] = bank_val(a);
    t.rdata = model_rd[m];
    iss_q.push_back(t);
    ack_q.push_back(t);
  endtask

  task automatic clear_inputs();
    bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    clear_inputs();
    model_rd[0] = '0; model_rd[1] = '0;
    iss_q.delete(); ack_q.delete();
    repeat (3) @(negedge clk);
    resetb = 1'b1;
  endtask

  // Counts negedges until the selected ack is seen; -1 on timeout.
  task automatic wait_ack(input bit m, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if ((m ? bus.m1_ack : bus.m0_ack) === 1'b1) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, owner} !== 2'b01) begin
      errors++; $display("[TB] FAIL reset_busy_owner: got %b, required 01", {busy, owner});
    end
    checks++;
    if ({bus.rb_we, bus.rb_re, bus.m0_ack, bus.m1_ack} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_strobes: got %b, required 0000",
                         {bus.rb_we, bus.rb_re, bus.m0_ack, bus.m1_ack});
    end
    checks++;
    if ({bus.rb_addr, bus.rb_wdata} !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_rb_bus: got %h, required 0000", {bus.rb_addr, bus.rb_wdata});
    end
    checks++;
    if ({bus.m0_rdata, bus.m1_rdata} !== 16'h0000) begin
      errors++; $display("[TB] FAIL reset_rdata: got %h, required 0000", {bus.m0_rdata, bus.m1_rdata});
    end
    do_reset();
  endtask

  task automatic test_single_write();
    int cyc;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 8'h05; bus.m0_wdata = 8'hA5;
    expect_txn(1'b0, 1'b1, 8'h05, 8'hA5);
    wait_ack(1'b0, cyc);
    bus.m0_req = 1'b0;
    checks++;
    if (cyc !== 2) begin
      errors++; $display("[TB] FAIL write_latency: got %0d, required 2", cyc);
    end
    @(negedge clk);
    checks++;
    if ({busy, owner} !== 2'b00) begin
      errors++; $display("[TB] FAIL write_idle: busy/owner got %b, required 00", {busy, owner});
    end
  endtask

  task automatic test_read();
    int cyc;
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 8'h07; bus.m1_wdata = 8'h00;
    expect_txn(1'b1, 1'b0, 8'h07, 8'h00);
    wait_ack(1'b1, cyc);
    bus.m1_req = 1'b0;
    checks++;
    if (cyc !== 2 + RD_LAT) begin
      errors++; $display("[TB] FAIL read_latency: got %0d, required %0d", cyc, 2 + RD_LAT);
    end
    @(negedge clk);
    checks++;
    if ({bus.m1_rdata, bus.m0_rdata} !== {8'h3C, 8'h00}) begin
      errors++; $display("[TB] FAIL read_retain: m1/m0 rdata got %h, required 3c00",
                         {bus.m1_rdata, bus.m0_rdata});
    end
  endtask

  task automatic test_tie();
    int cyc;
    do_reset();
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h10;
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 8'h20; bus.m1_wdata = 8'h77;
    expect_txn(1'b0, 1'b0, 8'h10, 8'h00);
    expect_txn(1'b1, 1'b1, 8'h20, 8'h77);
    expect_txn(1'b0, 1'b0, 8'h10, 8'h00);
    wait_ack(1'b0, cyc);
    checks++;
    if (cyc !== 2 + RD_LAT) begin
      errors++; $display("[TB] FAIL tie_first_m0: got %0d, required %0d", cyc, 2 + RD_LAT);
    end
    wait_ack(1'b1, cyc);
    checks++;
    if (cyc !== 3) begin
      errors++; $display("[TB] FAIL tie_then_m1: got %0d, required 3", cyc);
    end
    wait_ack(1'b0, cyc);
    bus.m0_req = 1'b0; bus.m1_req = 1'b0;
    checks++;
    if (cyc !== 3 + RD_LAT) begin
      errors++; $display("[TB] FAIL tie_then_m0: got %0d, required %0d", cyc, 3 + RD_LAT);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_busy_request();
    int cyc;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h30;
    expect_txn(1'b0, 1'b0, 8'h30, 8'h00);
    repeat (3) @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 8'h31; bus.m1_wdata = 8'h99;
    expect_txn(1'b1, 1'b1, 8'h31, 8'h99);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("[TB] FAIL busy_in_wait: got %b, required 1", busy);
    end
    wait_ack(1'b0, cyc);
    bus.m0_req = 1'b0;
    checks++;
    if (cyc !== 2) begin
      errors++; $display("[TB] FAIL busy_m0_ack: got %0d, required 2", cyc);
    end
    wait_ack(1'b1, cyc);
    bus.m1_req = 1'b0;
    checks++;
    if (cyc !== 3) begin
      errors++; $display("[TB] FAIL busy_m1_after: got %0d, required 3", cyc);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h40;
    expect_txn(1'b0, 1'b0, 8'h40, 8'h00);
    repeat (2) @(negedge clk);
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({busy, owner, bus.m0_ack, bus.rb_re, bus.rb_addr, bus.m0_rdata} !== {4'b0100, 16'h0000}) begin
      errors++; $display("[TB] FAIL midreset_outputs: got %b %b %b %b %h %h, required 0 1 0 0 00 00",
                         busy, owner, bus.m0_ack, bus.rb_re, bus.rb_addr, bus.m0_rdata);
    end
    iss_q.delete(); ack_q.delete();
    model_rd[0] = '0; model_rd[1] = '0;
    expect_txn(1'b0, 1'b0, 8'h40, 8'h00);
    @(negedge clk);
    checks++;
    if ({busy, bus.m0_ack} !== 2'b00) begin
      errors++; $display("[TB] FAIL midreset_held: busy/ack got %b, required 00", {busy, bus.m0_ack});
    end
    resetb = 1'b1;
    wait_ack(1'b0, cyc);
    bus.m0_req = 1'b0;
    checks++;
    if (cyc !== 2 + RD_LAT) begin
      errors++; $display("[TB] FAIL midreset_rearb: got %0d, required %0d", cyc, 2 + RD_LAT);
    end
  endtask

  task automatic test_field_change();
    bit done;
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 8'h01;
    expect_txn(1'b0, 1'b0, 8'h01, 8'h00);
    repeat (2) @(negedge clk);
    bus.m0_addr = 8'h02;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rb_addr !== 8'h01) begin
        errors++; $display("[TB] FAIL field_hold: rb_addr got %h, required 01", bus.rb_addr);
      end
      if (bus.m0_ack === 1'b1) done = 1'b1;
    end
    bus.m0_req = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("[TB] FAIL field_ack_timeout: ack seen %b, required 1", done);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    @(negedge clk);
    bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 8'h50; bus.m1_wdata = 8'h11;
    expect_txn(1'b1, 1'b1, 8'h50, 8'h11);
    wait_ack(1'b1, cyc);
    bus.m1_wdata = 8'h22;
    expect_txn(1'b1, 1'b1, 8'h50, 8'h22);
    wait_ack(1'b1, cyc);
    bus.m1_req = 1'b0;
    checks++;
    if (cyc !== 3) begin
      errors++; $display("[TB] FAIL b2b_second: got %0d, required 3", cyc);
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({iss_q.size(), ack_q.size()} !== 64'd0) begin
      errors++; $display("[TB] FAIL scoreboard_drain: issue=%0d ack=%0d left, required 0 0",
                         iss_q.size(), ack_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    resetb = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_read();
    test_tie();
    test_busy_request();
    test_mid_reset();
    test_field_change();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
